// File: rtl/clk_div_pkg.sv
// clk_div_pkg
// Shared definitions for the clock-divider controller slice:
//   state_t  - controller states (IDLE, RUN, DRAIN)
//   CW_DEF   - default width of the ratio and the division counter
//   half()   - high-phase length of a period of ratio N (floor(N/2))
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CW_DEF = 4;

  // The argument and result are 32 bits wide so that any CW can use this
  // function. The caller casts the result back down to CW bits.
  function automatic logic [31:0] half(input logic [31:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// clk_div_cnt
// Division counter with registered divided-clock and period-tick generation.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous reset, active-high
//   en       - 1 when the controller will be in RUN/DRAIN after this edge
//   load     - 1 while the controller is in IDLE; the first count after
//              a start is forced to 0
//   ratio    - ratio currently in force (cur_div)
//   boundary - cnt == ratio-1, which is the last cycle of a period
//   clk_div  - registered divided clock: floor(N/2) cycles high, then
//              ceil(N/2) cycles low
//   div_tick - one-cycle pulse on the first cycle of each period
module clk_div_cnt
  import clk_div_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] ratio,
  output logic          boundary,
  output logic          clk_div,
  output logic          div_tick
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_div_q, clk_div_d;
  logic          tick_q, tick_d;
  logic [CW-1:0] half_w;

  assign half_w = CW'(half(32'(ratio)));

  // In IDLE, cnt is 0 and ratio is at least 2, so this comparison stays
  // false there without any extra state qualification.
  assign boundary = (cnt_q == ratio - CW'(1));

  // When the ratio changes at a boundary, the counter wraps to 0. Because
  // every legal ratio has half >= 1, the first cycle of the new period is
  // high whether the old or the new ratio is used here. Reading the old
  // ratio therefore cannot create a runt pulse.
  always_comb begin
    cnt_d = '0;
    if (en && !load && !boundary) begin
      cnt_d = cnt_q + CW'(1);
    end
    clk_div_d = en && (cnt_d < half_w);
    tick_d    = en && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_div  = clk_div_q;
  assign div_tick = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
// Runtime controller for an integer clock divider. It handles start/stop
// sequencing and changes of the divide ratio. Stops and ratio changes take
// effect only at a period boundary, so clk_div never shows a glitch.
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous reset, active-high
//   run       - level; 1 = run, 0 = stop at the next period boundary
//   cfg_div   - requested ratio, sampled while cfg_req is high
//   cfg_req   - level request, held until cfg_ack
//   cfg_ack   - one-cycle pulse when a request is accepted or rejected
//   cfg_err   - valid with cfg_ack; 1 = rejected (cfg_div < 2)
//   clk_div   - registered divided clock
//   div_tick  - pulse on the first cycle of each divided period
//   cur_div   - ratio currently in force
//   odd_ratio - cur_div[0], for the downstream negedge duty-correction cell
//   busy      - 1 in RUN or DRAIN
// DIV_DEF must lie in 2..2^CW-1.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int DIV_DEF = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [CW-1:0] cfg_div,
  input  logic          cfg_req,
  output logic          cfg_ack,
  output logic          cfg_err,
  output logic          clk_div,
  output logic          div_tick,
  output logic [CW-1:0] cur_div,
  output logic          odd_ratio,
  output logic          busy
);

  state_t        state_q, state_d;
  logic [CW-1:0] cur_div_q, cur_div_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;

  logic          boundary;
  logic          req_live;
  logic          req_valid;
  logic          cnt_en;
  logic          cnt_load;

  // The requester still holds cfg_req during the cycle in which the ack is
  // visible. Masking the request in that cycle stops one held request from
  // being acknowledged twice.
  assign req_live  = cfg_req && !ack_q;
  assign req_valid = (cfg_div >= CW'(2));

  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = RUN;
        end
        // With no period in flight, a valid ratio takes effect at once.
        // If run rises on the same edge, the first period uses this ratio.
        if (req_live && req_valid) begin
          cur_div_d = cfg_div;
          ack_d     = 1'b1;
        end
      end

      RUN, DRAIN: begin
        if (boundary && !run) begin
          state_d = IDLE;
        end else if (run) begin
          state_d = RUN;
        end else begin
          state_d = DRAIN;
        end
        if (boundary && req_live && req_valid) begin
          cur_div_d = cfg_div;
          ack_d     = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A rejected ratio never waits for a boundary.
    if (req_live && !req_valid) begin
      ack_d = 1'b1;
      err_d = 1'b1;
    end
  end

  assign cnt_en   = (state_d != IDLE);
  assign cnt_load = (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_div_q <= CW'(DIV_DEF);
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_div_q <= cur_div_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  clk_div_cnt #(
    .CW(CW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .load     (cnt_load),
    .ratio    (cur_div_q),
    .boundary (boundary),
    .clk_div  (clk_div),
    .div_tick (div_tick)
  );

  assign cfg_ack   = ack_q;
  assign cfg_err   = err_q;
  assign cur_div   = cur_div_q;
  assign odd_ratio = cur_div_q[0];
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  logic       clk;
  logic       rst;
  logic       run;
  logic [3:0] cfg_div;
  logic       cfg_req;
  logic       cfg_ack;
  logic       cfg_err;
  logic       clk_div;
  logic       div_tick;
  logic [3:0] cur_div;
  logic       odd_ratio;
  logic       busy;

  clk_div_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .cfg_div   (cfg_div),
    .cfg_req   (cfg_req),
    .cfg_ack   (cfg_ack),
    .cfg_err   (cfg_err),
    .clk_div   (clk_div),
    .div_tick  (div_tick),
    .cur_div   (cur_div),
    .odd_ratio (odd_ratio),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int hi;
    int lo;
    int div;
  } per_t;

  typedef struct packed {
    int err;
    int div;
  } ack_t;

  per_t per_q[$];
  ack_t ack_q[$];

  int pass_cnt;
  int total_cnt;
  int t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic fail_evt(input string name);
    total_cnt++;
    $display("FAIL %s: DUT produced an event with nothing expected (time %0t)", name, $time);
  endtask

  task automatic push_per(input int hi, input int lo, input int div, input int n);
    for (int i = 0; i < n; i++) begin
      per_q.push_back('{hi: hi, lo: lo, div: div});
    end
  endtask

  task automatic push_ack(input int err, input int div);
    ack_q.push_back('{err: err, div: div});
  endtask

  // Move to just after the edge at which the cycle index becomes target.
  task automatic adv(input int target);
    while (t < target) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clk_div"},   clk_div,   0);
    chk({tag, "_div_tick"},  div_tick,  0);
    chk({tag, "_cfg_ack"},   cfg_ack,   0);
    chk({tag, "_cfg_err"},   cfg_err,   0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_cur_div"},   cur_div,   9);
    chk({tag, "_odd_ratio"}, odd_ratio, 1);
  endtask

  // Monitor: samples on the falling edge and pops expectations when the DUT
  // presents an ack or a period tick.
  int   m_hi;
  int   m_lo;
  bit   m_rerise;
  bit   m_in_per;
  per_t m_exp;
  ack_t m_ack;

  task automatic finish_period();
    chk("period_high_cycles", m_hi, m_exp.hi);
    chk("period_low_cycles",  m_lo, m_exp.lo);
    chk("period_no_runt",     m_rerise, 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_in_per = 1'b0;
    end else begin
      if (cfg_ack) begin
        if (ack_q.size() == 0) begin
          fail_evt("unexpected_cfg_ack");
        end else begin
          m_ack = ack_q.pop_front();
          chk("ack_cfg_err", cfg_err, m_ack.err);
          chk("ack_cur_div", cur_div, m_ack.div);
        end
      end
      if (div_tick) begin
        if (m_in_per) finish_period();
        if (per_q.size() == 0) begin
          fail_evt("unexpected_div_tick");
          m_in_per = 1'b0;
        end else begin
          m_exp = per_q.pop_front();
          chk("tick_cur_div",   cur_div,   m_exp.div);
          chk("tick_odd_ratio", odd_ratio, m_exp.div & 1);
          m_in_per = 1'b1;
          m_hi     = 0;
          m_lo     = 0;
          m_rerise = 1'b0;
        end
      end else if (!busy) begin
        if (m_in_per) begin
          finish_period();
          m_in_per = 1'b0;
        end
        chk("idle_clk_div", clk_div, 0);
      end
      if (m_in_per) begin
        if (clk_div) begin
          if (m_lo > 0) m_rerise = 1'b1;
          m_hi++;
        end else begin
          m_lo++;
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    m_in_per = 1'b0;
    rst = 1'b0;
    run = 1'b0;
    cfg_req = 1'b0;
    cfg_div = 4'd0;
    t = 0;

    // Expected periods: {high, low, ratio}
    push_per(4, 5, 9, 3);   // start at default ratio 9
    push_per(2, 2, 4, 2);   // after switching to 4
    push_per(4, 5, 9, 4);   // back at 9, invalid request, stop, drain/resume
    push_per(1, 2, 3, 2);   // start with ratio 3 applied in IDLE
    push_per(3, 4, 7, 2);   // ratio 7; second period is cut by reset
    push_per(4, 5, 9, 1);   // after reset, default ratio again
    push_per(7, 8, 15, 2);  // maximum ratio
    // Expected acks: {err, cur_div at ack}
    push_ack(0, 4);
    push_ack(0, 9);
    push_ack(1, 9);
    push_ack(0, 3);
    push_ack(0, 7);
    push_ack(1, 9);
    push_ack(0, 15);

    // Asynchronous reset with no clock edge yet
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("reset");

    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run = 1'b1;
    t = -1;
    adv(0);
    chk("start_div_tick", div_tick, 1);
    chk("start_clk_div",  clk_div,  1);
    chk("start_busy",     busy,     1);

    adv(20); cfg_div = 4'd4; cfg_req = 1'b1;  // period 3, cnt=2
    adv(28); cfg_req = 1'b0;
    adv(32); cfg_div = 4'd9; cfg_req = 1'b1;
    adv(36); cfg_req = 1'b0;
    adv(38); cfg_div = 4'd1; cfg_req = 1'b1;  // invalid, period at 9 cnt=3
    adv(40); cfg_req = 1'b0;
    adv(47); run = 1'b0;                      // cnt=3
    adv(53);
    chk("stop_busy",    busy,    0);
    chk("stop_clk_div", clk_div, 0);
    adv(54); run = 1'b1;
    adv(57); run = 1'b0;                      // DRAIN
    adv(61); run = 1'b1;                      // cnt=6, resume
    adv(66); run = 1'b0;
    adv(74); cfg_div = 4'd3; cfg_req = 1'b1; run = 1'b1;
    adv(75);
    chk("idle_req_start_tick", div_tick, 1);
    chk("idle_req_start_cur",  cur_div,  3);
    adv(76); cfg_req = 1'b0;
    adv(79); cfg_div = 4'd7; cfg_req = 1'b1;
    adv(82); cfg_req = 1'b0;
    adv(91); cfg_div = 4'd5; cfg_req = 1'b1;  // pending, lost at reset
    adv(93);
    #2 rst = 1'b1;                            // mid-cycle, cnt=5
    #1;
    chk_reset_vals("midreset");
    cfg_req = 1'b0;

    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = -1;
    adv(0);
    chk("restart_div_tick", div_tick, 1);
    chk("restart_cur_div",  cur_div,  9);
    adv(2);  run = 1'b0;
    adv(9);  cfg_div = 4'd0; cfg_req = 1'b1;  // invalid in IDLE
    adv(11); cfg_req = 1'b0;
    adv(12); cfg_div = 4'd15; cfg_req = 1'b1; // valid in IDLE
    adv(14); cfg_req = 1'b0;
    adv(15); run = 1'b1;
    adv(33); run = 1'b0;
    adv(50);

    chk("periods_remaining", per_q.size(), 0);
    chk("acks_remaining",    ack_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
